nanorv32_test_monitor: RTL

Synthesizable, parametrised test-completion and console monitor for nanorv32 simulation and FPGA bring-up. Watches the core's retire stream (PC, a0, illegal-instruction flag) and reports a sticky pass/fail/timeout verdict. It also captures putc-style characters into a FIFO drained by a valid/ready consumer, such as a UART or bench printer. It sits beside the CPU, fed from the execute stage, and replaces simulator-only pass/fail and printf checks.

---
 rtl/nanorv32_monitor_pkg.sv | 22 ++
 rtl/nanorv32_char_fifo.sv | 49 ++++
 rtl/nanorv32_test_monitor.sv | 100 ++++++++++
 3 files changed

// File: rtl/nanorv32_monitor_pkg.sv
`default_nettype none
// nanorv32_monitor_pkg -- verdict encoding and default constants for the nanorv32 test monitor.
// Rev 1.0
package nanorv32_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_UNKNOWN = 3'd3,
    ST_ILLEGAL = 3'd4,
    ST_TIMEOUT = 3'd5
  } mon_status_e;

  localparam logic [31:0] DEF_DONE_PC   = 32'h0000_0100;
  localparam logic [31:0] DEF_PUTC_PC   = 32'h0000_0088;
  localparam logic [31:0] DEF_PASS_CODE = 32'hCAFF_E000;
  localparam logic [31:0] DEF_FAIL_CODE = 32'hDEAD_D000;
  localparam logic [7:0]  CHAR_EOL      = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/nanorv32_char_fifo.sv
`default_nettype none
// nanorv32_char_fifo -- synchronous FIFO with wrap-bit pointers and a registered-storage head.
// Rev 1.0
module nanorv32_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot being written, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/nanorv32_test_monitor.sv
`default_nettype none
// nanorv32_test_monitor -- sticky pass/fail/timeout verdict and putc console capture.
// Rev 1.0
module nanorv32_test_monitor
  import nanorv32_monitor_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] DONE_PC    = DEF_DONE_PC,
  parameter logic [DATA_W-1:0] PUTC_PC    = DEF_PUTC_PC,
  parameter logic [DATA_W-1:0] PASS_CODE  = DEF_PASS_CODE,
  parameter logic [DATA_W-1:0] FAIL_CODE  = DEF_FAIL_CODE,
  parameter int                FIFO_DEPTH = 16,
  parameter int                WDOG_W     = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 24'hFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ret,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] a0,
  input  logic              illegal_instruction,
  output logic              char_valid,
  output logic [7:0]        char_data,
  output logic              char_eol,
  input  logic              char_ready,
  output logic              done,
  output logic [2:0]        status,
  output logic [7:0]        drop_cnt
);

  localparam logic [WDOG_W-1:0] WDOG_ONE = 1;

  mon_status_e       state;
  mon_status_e       state_nxt;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wdog_nxt;
  logic              done_hit;
  logic              putc_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic              drop;

  assign done_hit  = inst_ret && (pc == DONE_PC);
  assign putc_push = inst_ret && (pc == PUTC_PC) && (state == ST_RUN);
  assign drop      = putc_push && fifo_full && !char_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wdog     <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    if (state == ST_RUN) begin
      wdog_nxt = inst_ret ? '0 : (wdog + WDOG_ONE);
      if (illegal_instruction) begin
        state_nxt = ST_ILLEGAL;
      end else if (done_hit) begin
        if (a0 == PASS_CODE)      state_nxt = ST_PASS;
        else if (a0 == FAIL_CODE) state_nxt = ST_FAIL;
        else                      state_nxt = ST_UNKNOWN;
      end else if (!inst_ret && (wdog == WDOG_LIMIT)) begin
        state_nxt = ST_TIMEOUT;
      end
    end
  end

  assign done   = (state != ST_RUN);
  assign status = state;

  nanorv32_char_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_char_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (putc_push),
    .din   (a0[7:0]),
    .pop   (char_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Head storage is not reset, so mask it to keep an idle bus at zero.
  assign char_valid = !fifo_empty;
  assign char_data  = char_valid ? fifo_head : 8'h00;
  assign char_eol   = char_valid && (fifo_head == CHAR_EOL);

endmodule
`default_nettype wire
